smpl_iter_ctrl: RTL

- Per-triangle sample scheduler. It sits between the bounding-box stage (R13) and the sample-test datapath (R14).
- It accepts one snapped bounding box plus its triangle and color, then walks the box on the subsample grid in raster order.
- Each cycle it issues SAMPLES horizontally adjacent sample positions to the sample-test units.
- It back-pressures the bbox stage while iterating and obeys a stall from downstream.

---
 rtl/smpl_iter_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/smpl_iter_ctrl.sv
// Per-triangle sample scheduler: walks a snapped bounding box on the subsample
// grid in raster order, issuing SAMPLES horizontally adjacent positions per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_WAIT | idle, ready for a box (halt_R13L=1); degenerate boxes dropped here
// ST_TEST | iterating; registered R14 group is live, advances when halt_R14L=1
module smpl_iter_ctrl #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic        [1:0]        ss_lg2_R13U,
  input  logic                     validTri_R13H,
  output logic                     halt_R13L,
  input  logic                     halt_R14L,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [SAMPLES][2],
  output logic        [SAMPLES-1:0] validSamp_R14H
);

  typedef logic signed [SIGFIG-1:0] pos_t;
  typedef enum logic {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

  state_t state_q, state_d;
  pos_t   x_q, x_d;
  pos_t   y_q, y_d;
  pos_t   ll_x_q, ll_x_d;
  pos_t   ur_x_q, ur_x_d;
  pos_t   ur_y_q, ur_y_d;
  pos_t   step_q, step_d;
  pos_t   tri_q [VERTS][AXIS];
  pos_t   tri_d [VERTS][AXIS];
  logic [SIGFIG-1:0] color_q [COLORS];
  logic [SIGFIG-1:0] color_d [COLORS];
  pos_t   samp_q [SAMPLES][2];
  pos_t   samp_d [SAMPLES][2];
  logic [SAMPLES-1:0] valid_q, valid_d;

  pos_t   step_in;
  pos_t   box_ll_x, box_ll_y, box_ur_x, box_ur_y;
  logic   box_degen;
  pos_t   step_span;
  pos_t   nx, ny;

  // Group to be loaded into the R14 registers this cycle.
  logic   grp_load;
  logic   grp_done;
  pos_t   grp_x, grp_y, grp_step, grp_urx;
  pos_t   lane_x [SAMPLES];
  logic [SAMPLES-1:0] lane_ok;

  always_comb begin
    step_in   = pos_t'(1) << (RADIX - int'(ss_lg2_R13U));
    box_ll_x  = box_R13S[0][0];
    box_ll_y  = box_R13S[0][1];
    box_ur_x  = box_R13S[1][0];
    box_ur_y  = box_R13S[1][1];
    box_degen = (box_ll_x > box_ur_x) || (box_ll_y > box_ur_y);
    step_span = pos_t'(SAMPLES) * step_q;
    nx        = x_q + step_span;
    ny        = y_q + step_q;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ll_x_d   = ll_x_q;
    ur_x_d   = ur_x_q;
    ur_y_d   = ur_y_q;
    step_d   = step_q;
    tri_d    = tri_q;
    color_d  = color_q;
    grp_load = 1'b0;
    grp_done = 1'b0;
    grp_x    = x_q;
    grp_y    = y_q;
    grp_step = step_q;
    grp_urx  = ur_x_q;
    case (state_q)
      ST_WAIT: begin
        if (validTri_R13H) begin
          tri_d   = tri_R13S;
          color_d = color_R13U;
          step_d  = step_in;
          ll_x_d  = box_ll_x;
          ur_x_d  = box_ur_x;
          ur_y_d  = box_ur_y;
          x_d     = box_ll_x;
          y_d     = box_ll_y;
          if (!box_degen) begin
            state_d  = ST_TEST;
            grp_load = 1'b1;
            grp_x    = box_ll_x;
            grp_y    = box_ll_y;
            grp_step = step_in;
            grp_urx  = box_ur_x;
          end
        end
      end
      ST_TEST: begin
        if (halt_R14L) begin
          if (nx <= ur_x_q) begin
            x_d      = nx;
            grp_load = 1'b1;
            grp_x    = nx;
          end else if (ny <= ur_y_q) begin
            x_d      = ll_x_q;
            y_d      = ny;
            grp_load = 1'b1;
            grp_x    = ll_x_q;
            grp_y    = ny;
          end else begin
            state_d  = ST_WAIT;
            grp_done = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      lane_x[i]  = grp_x + pos_t'(i) * grp_step;
      lane_ok[i] = (lane_x[i] <= grp_urx);
    end
  end

  // R14 group register: loads a new group, clears on exit, otherwise holds (stall).
  always_comb begin
    samp_d  = samp_q;
    valid_d = valid_q;
    if (grp_load) begin
      for (int i = 0; i < SAMPLES; i++) begin
        samp_d[i][0] = lane_x[i];
        samp_d[i][1] = grp_y;
      end
      valid_d = lane_ok;
    end else if (grp_done) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      tri_q   <= '{default: '0};
      color_q <= '{default: '0};
      samp_q  <= '{default: '0};
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      step_q  <= step_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
    end
  end

  assign halt_R13L      = (state_q == ST_WAIT);
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = samp_q;
  assign validSamp_R14H = valid_q;

endmodule
